// File: rtl/kbd_text_buf.sv
// rtl/kbd_text_buf.sv - PS/2 scan-code driven character buffer with cursor and registered renderer read port
// The buffer is swept to spaces after reset; popped bytes then drive make/break/extended decoding.
module kbd_text_buf #(
   parameter int COLS  = 70,
   parameter int ROWS  = 30,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              kb_data,
   input  logic                    kb_ready,
   output logic                    kb_nextdata_n,
   input  logic [$clog2(COLS)-1:0] rd_col,
   input  logic [$clog2(ROWS)-1:0] rd_row,
   output logic [7:0]              rd_char,
   output logic [$clog2(COLS)-1:0] cur_col,
   output logic [$clog2(ROWS)-1:0] cur_row,
   output logic [7:0]              last_scan,
   output logic [7:0]              last_ascii,
   output logic [CNT_W-1:0]        key_cnt,
   output logic                    busy
);
   localparam int CW    = $clog2(COLS);
   localparam int RW    = $clog2(ROWS);
   localparam int CELLS = COLS * ROWS;
   localparam int AW    = $clog2(CELLS);

   typedef enum logic [2:0] {CLEAR, IDLE, POP, BREAK, EXT} state_t;
   state_t state, state_nx;

   logic [7:0]    mem [CELLS];
   logic [AW-1:0] clr_addr;
   logic [7:0]    byte_q, held, ascii;
   logic          brk_flag, ext_flag;
   logic          wr_en;
   logic [AW-1:0] wr_addr, addr_cur, rd_addr;
   logic [7:0]    wr_data;
   logic [RW-1:0] row_inc;
   logic          is_data;

   assign addr_cur = AW'(cur_row) * AW'(COLS) + AW'(cur_col);
   assign rd_addr  = AW'(rd_row) * AW'(COLS) + AW'(rd_col);
   assign row_inc  = (cur_row == RW'(ROWS - 1)) ? '0 : cur_row + RW'(1);
   assign is_data  = (state == POP) && (byte_q != 8'hF0) && (byte_q != 8'hE0);

   always_ff @(posedge clk) begin
      if (rst) state <= CLEAR;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         CLEAR:           if (clr_addr == AW'(CELLS - 1)) state_nx = IDLE;
         IDLE, BREAK, EXT: if (kb_ready) state_nx = POP;
         POP: begin
            if (byte_q == 8'hF0)      state_nx = BREAK;
            else if (byte_q == 8'hE0) state_nx = EXT;
            else                      state_nx = IDLE;
         end
         default:         state_nx = CLEAR;
      endcase
   end

   always_comb begin
      kb_nextdata_n = 1'b1;
      busy          = 1'b0;
      case (state)
         CLEAR:   busy = 1'b1;
         POP:     kb_nextdata_n = 1'b0;
         default: begin end
      endcase
   end

   // Scan code set 2 to ASCII; only the keys the terminal understands are mapped.
   always_comb begin
      ascii = 8'h00;
      case (byte_q)
         8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;  8'h23: ascii = 8'h64;
         8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;  8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;
         8'h43: ascii = 8'h69;  8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
         8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;  8'h4D: ascii = 8'h70;
         8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;  8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;
         8'h3C: ascii = 8'h75;  8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
         8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
         8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;  8'h26: ascii = 8'h33;
         8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;  8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;
         8'h3E: ascii = 8'h38;  8'h46: ascii = 8'h39;
         8'h29: ascii = 8'h20;  8'h5A: ascii = 8'h0D;  8'h66: ascii = 8'h08;
         default: ascii = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clr_addr   <= '0;
         cur_col    <= '0;
         cur_row    <= '0;
         last_scan  <= 8'h00;
         last_ascii <= 8'h00;
         key_cnt    <= '0;
         held       <= 8'h00;
         byte_q     <= 8'h00;
         brk_flag   <= 1'b0;
         ext_flag   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 8'h00;
      end else begin
         wr_en <= 1'b0;
         if (state == CLEAR) clr_addr <= clr_addr + AW'(1);
         // The flags remember which waiting state the popped byte belongs to.
         if ((state == IDLE || state == BREAK || state == EXT) && kb_ready) begin
            byte_q   <= kb_data;
            brk_flag <= (state == BREAK);
            ext_flag <= (state == EXT);
         end
         if (is_data) begin
            if (brk_flag) begin
               if (held == byte_q) held <= 8'h00;
            end else if (ext_flag) begin
               last_scan <= byte_q;
            end else begin
               if (byte_q != held) begin
                  held    <= byte_q;
                  key_cnt <= key_cnt + CNT_W'(1);
               end
               last_scan  <= byte_q;
               last_ascii <= ascii;
               if (ascii == 8'h0D) begin
                  cur_col <= '0;
                  cur_row <= row_inc;
               end else if (ascii == 8'h08) begin
                  // Row-major layout makes the previous cell addr-1 even across a row boundary.
                  if (cur_col != '0 || cur_row != '0) begin
                     wr_en   <= 1'b1;
                     wr_addr <= addr_cur - AW'(1);
                     wr_data <= 8'h20;
                     if (cur_col != '0) begin
                        cur_col <= cur_col - CW'(1);
                     end else begin
                        cur_col <= CW'(COLS - 1);
                        cur_row <= cur_row - RW'(1);
                     end
                  end
               end else if (ascii != 8'h00) begin
                  wr_en   <= 1'b1;
                  wr_addr <= addr_cur;
                  wr_data <= ascii;
                  if (cur_col == CW'(COLS - 1)) begin
                     cur_col <= '0;
                     cur_row <= row_inc;
                  end else begin
                     cur_col <= cur_col + CW'(1);
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && state == CLEAR) mem[clr_addr] <= 8'h20;
      else if (!rst && wr_en)     mem[wr_addr]  <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst)                                          rd_char <= 8'h00;
      else if (int'(rd_col) < COLS && int'(rd_row) < ROWS) rd_char <= mem[rd_addr];
      else                                              rd_char <= 8'h00;
   end
endmodule

// File: doc/kbd_text_buf.md
KBD_TEXT_BUF -- requirements
Module: kbd_text_buf

Interface
REQ-001 SHALL have parameter COLS, default 70, the number of character columns.
REQ-002 SHALL have parameter ROWS, default 30, the number of character rows.
REQ-003 SHALL have parameter CNT_W, default 8, the width of the key-press counter.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port kb_data  input  8  scan-code byte from the PS/2 receiver FIFO head.
REQ-007 SHALL have port kb_ready  input  1  high when kb_data is valid.
REQ-008 SHALL have port kb_nextdata_n  output  1  active-low one-cycle pop strobe to the receiver.
REQ-009 SHALL have port rd_col  input  $clog2(COLS)  renderer read column.
REQ-010 SHALL have port rd_row  input  $clog2(ROWS)  renderer read row.
REQ-011 SHALL have port rd_char  output  8  ASCII character at (rd_row, rd_col).
REQ-012 SHALL have ports cur_col / cur_row  output  $clog2(COLS) / $clog2(ROWS)  cursor position.
REQ-013 SHALL have ports last_scan  output  8  and last_ascii  output  8  for the most recent make event.
REQ-014 SHALL have ports key_cnt  output  CNT_W  and busy  output  1  (high while the buffer is being cleared).

Function
REQ-015 SHALL use FSM states CLEAR, IDLE, POP, BREAK, EXT.
REQ-016 CLEAR: SHALL write 0x20 to one cell per cycle, row-major, COLS*ROWS cycles, with busy=1 and kb_nextdata_n=1; after the last cell SHALL go to IDLE.
REQ-017 IDLE with kb_ready=1: SHALL capture kb_data and drive kb_nextdata_n=0 for exactly one cycle (POP).
REQ-018 After POP: byte F0 SHALL go to BREAK; byte E0 SHALL go to EXT; any other byte SHALL be a make event and return to IDLE.
REQ-019 BREAK: the next popped byte SHALL be a release, SHALL clear the held code if it matches, SHALL write nothing, and SHALL return to IDLE.
REQ-020 EXT: the next byte SHALL update last_scan only, with no write and no count. An F0 byte in EXT SHALL chain to BREAK.
REQ-021 Make event equal to the held code (typematic repeat): SHALL write the character but SHALL NOT increment key_cnt.
REQ-022 New make event: SHALL set the held code, SHALL increment key_cnt modulo 2^CNT_W, and SHALL update last_scan and last_ascii.
REQ-023 Scan-to-ASCII map:
- codes for a-z SHALL map to lowercase 0x61-0x7A;
- main-row 0-9 SHALL map to 0x30-0x39;
- 29h SHALL map to 0x20;
- 5Ah SHALL map to 0x0D;
- 66h SHALL map to 0x08;
- all other codes SHALL map to 0x00.
REQ-024 Printable character: SHALL write it at the cursor, then advance cur_col. From col COLS-1, SHALL go to col 0 of the next row. From row ROWS-1, SHALL wrap to row 0 (no scroll).
REQ-025 0x0D: SHALL set col=0 and advance the row with the same wrap, with no write.
REQ-026 0x08: if col>0, SHALL decrement col and write 0x20 there. If col=0 and row>0, SHALL go to (row-1, COLS-1) and write 0x20 there. At (0,0), SHALL have no effect.
REQ-027 0x00: SHALL NOT write and SHALL NOT move the cursor; last_scan/last_ascii and key_cnt still update per REQ-022.
REQ-028 Buffer write SHALL occur in the cycle after POP. At most one write per cycle.
REQ-029 rd_char SHALL be registered, with 1-cycle latency. Out-of-range rd_col/rd_row SHALL return 0x00. A simultaneous write to the same cell SHALL return the old data.

Reset
REQ-030 rst SHALL force state CLEAR and restart the sweep from cell 0, including when asserted mid-sweep or mid-pop.
REQ-031 rst SHALL set kb_nextdata_n=1, busy=1, cursor (0,0), last_scan=0, last_ascii=0, key_cnt=0, rd_char=0, held code=0, and clear the break/ext flags.

Verification
REQ-032 Reset, then hold kb_ready=1 -> busy=1 and no pop for COLS*ROWS cycles; every cell reads 0x20 afterward.
REQ-033 Bytes 15h, F0, 15h -> 'q' (0x71) at (0,0), cursor (0,1), key_cnt=1; exactly three one-cycle kb_nextdata_n pulses.
REQ-034 Three 1Ch makes with no break -> "aaa" written, key_cnt=1 (repeats not counted).
REQ-035 Type 71 printable keys from (0,0) with COLS=70 -> wrap to (1,1). Enter at row ROWS-1 -> (0,0).
REQ-036 Backspace at (1,0) -> cursor (0,69) and cell (0,69)=0x20. Backspace at (0,0) -> no change.
REQ-037 E0,75 then E0,F0,75 -> last_scan=75h, no write, key_cnt unchanged. rst asserted mid-stream -> full REQ-031 state.
